// File: rtl/dtw_sched_pkg.sv
// dtw_sched_pkg: shared types and constants for the DTW query scheduler.
// Provides FSM state encodings, result record length and an index-width helper.
package dtw_sched_pkg;

    typedef enum logic [1:0] {
        D_IDLE,
        D_PICK,
        D_XFER
    } disp_state_t;

    typedef enum logic {
        C_IDLE,
        C_XFER
    } coll_state_t;

    localparam int RES_WORDS = 3;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtw_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority rotation.
// Ports: req (request vector), last (previous grant) -> gnt_idx, gnt_valid.
module rr_arbiter
    import dtw_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Scan from the farthest candidate back to last+1 so the nearest
    // requester after the previous grant is the one left standing.
    always_comb begin
        int j;
        j         = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            j = (int'(last) + i) % N;
            if (req[j]) begin
                gnt_idx   = IW'(j);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtw_sched.sv
// dtw_sched: splits the host query stream into packets, deals them to free DTW
// cores round-robin, and merges 3-word result records into one sink stream.
// Ports: host source FIFO (src_*), per-core source/result FIFOs (core_*),
// host sink FIFO (sink_*), run enable rs, busy flag and packet/record counters.
module dtw_sched
    import dtw_sched_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int AXIS_WIDTH = 32,
    parameter int SQG_SIZE   = 250
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rs,
    output logic                            busy,
    input  logic                            src_fifo_empty,
    input  logic [AXIS_WIDTH-1:0]           src_fifo_data,
    output logic                            src_fifo_rden,
    output logic [NUM_CORES-1:0]            core_src_wren,
    input  logic [NUM_CORES-1:0]            core_src_full,
    output logic [AXIS_WIDTH-1:0]           core_src_data,
    input  logic [NUM_CORES-1:0]            core_res_empty,
    input  logic [NUM_CORES*AXIS_WIDTH-1:0] core_res_data,
    output logic [NUM_CORES-1:0]            core_res_rden,
    output logic                            sink_fifo_wren,
    input  logic                            sink_fifo_full,
    output logic [AXIS_WIDTH-1:0]           sink_fifo_data,
    output logic                            sink_fifo_last,
    output logic [31:0]                     n_dispatched,
    output logic [31:0]                     n_returned
);

    localparam int CW = idx_w(NUM_CORES);
    localparam int WW = $clog2(SQG_SIZE + 1);
    localparam logic [CW-1:0] LAST_RST = CW'(NUM_CORES - 1);

    disp_state_t d_q, d_d;
    coll_state_t c_q, c_d;

    logic [CW-1:0]         sel_q, dlast_q, csel_q, clast_q;
    logic [WW-1:0]         wcnt_q;
    logic [1:0]            rcnt_q;
    logic [NUM_CORES-1:0]  alloc_q, alloc_d;
    logic [NUM_CORES-1:0]  free_req, res_req;
    logic [CW-1:0]         d_gnt, c_gnt;
    logic                  d_gnt_v, c_gnt_v;
    logic                  xfer, pop, xfer_end, rec_end;
    logic [AXIS_WIDTH-1:0] res_word;

    assign free_req = ~alloc_q;
    assign res_req  = ~core_res_empty;

    rr_arbiter #(.N(NUM_CORES)) u_free_arb (
        .req       (free_req),
        .last      (dlast_q),
        .gnt_idx   (d_gnt),
        .gnt_valid (d_gnt_v)
    );

    rr_arbiter #(.N(NUM_CORES)) u_res_arb (
        .req       (res_req),
        .last      (clast_q),
        .gnt_idx   (c_gnt),
        .gnt_valid (c_gnt_v)
    );

    always_comb begin
        d_d      = d_q;
        xfer     = 1'b0;
        xfer_end = 1'b0;
        unique case (d_q)
            D_IDLE: if (rs && !src_fifo_empty) d_d = D_PICK;
            D_PICK: if (d_gnt_v) d_d = D_XFER;
            D_XFER: begin
                xfer     = !src_fifo_empty && !core_src_full[sel_q];
                xfer_end = xfer && (wcnt_q == WW'(SQG_SIZE));
                if (xfer_end) d_d = D_IDLE;
            end
            default: d_d = D_IDLE;
        endcase
    end

    always_comb begin
        c_d     = c_q;
        pop     = 1'b0;
        rec_end = 1'b0;
        unique case (c_q)
            C_IDLE: if (c_gnt_v) c_d = C_XFER;
            C_XFER: begin
                pop     = !core_res_empty[csel_q] && !sink_fifo_full;
                rec_end = pop && (rcnt_q == 2'(RES_WORDS - 1));
                if (rec_end) c_d = C_IDLE;
            end
            default: c_d = C_IDLE;
        endcase
    end

    // A slot freed this cycle only becomes grantable next cycle,
    // since the arbiter looks at the registered vector.
    always_comb begin
        alloc_d = alloc_q;
        if (rec_end) alloc_d[csel_q] = 1'b0;
        if (xfer && wcnt_q == '0) alloc_d[sel_q] = 1'b1;
    end

    assign res_word      = core_res_data[int'(csel_q)*AXIS_WIDTH +: AXIS_WIDTH];
    assign src_fifo_rden = xfer;
    assign core_src_wren = xfer ? (NUM_CORES'(1) << sel_q) : '0;
    assign core_src_data = xfer ? src_fifo_data : '0;
    assign core_res_rden = pop ? (NUM_CORES'(1) << csel_q) : '0;
    assign busy = (d_q != D_IDLE) || (|alloc_q) || (c_q != C_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q            <= D_IDLE;
            c_q            <= C_IDLE;
            sel_q          <= '0;
            dlast_q        <= LAST_RST;
            csel_q         <= '0;
            clast_q        <= LAST_RST;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            alloc_q        <= '0;
            sink_fifo_wren <= 1'b0;
            sink_fifo_last <= 1'b0;
            sink_fifo_data <= '0;
            n_dispatched   <= '0;
            n_returned     <= '0;
        end else begin
            d_q     <= d_d;
            c_q     <= c_d;
            alloc_q <= alloc_d;
            if (d_q == D_PICK && d_gnt_v) begin
                sel_q   <= d_gnt;
                dlast_q <= d_gnt;
                wcnt_q  <= '0;
            end else if (xfer) begin
                wcnt_q <= wcnt_q + WW'(1);
            end
            if (xfer_end) n_dispatched <= n_dispatched + 32'd1;
            if (c_q == C_IDLE && c_gnt_v) begin
                csel_q  <= c_gnt;
                clast_q <= c_gnt;
                rcnt_q  <= '0;
            end else if (pop) begin
                rcnt_q <= rcnt_q + 2'd1;
            end
            if (rec_end) n_returned <= n_returned + 32'd1;
            sink_fifo_wren <= pop;
            sink_fifo_last <= rec_end;
            if (pop) sink_fifo_data <= res_word;
        end
    end

endmodule

// File: tb/tb_dtw_sched.sv
// tb_dtw_sched: directed-sequence bench with random payloads for dtw_sched.
// Models host/core FIFOs as queues and checks dispatch, merge and reset.
module tb_dtw_sched;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int SQ = 8;
    localparam int PK = SQ + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rs  = 1'b0;
    logic          busy;
    logic          src_fifo_empty = 1'b1;
    logic [W-1:0]  src_fifo_data  = '0;
    logic          src_fifo_rden;
    logic [NC-1:0] core_src_wren;
    logic [NC-1:0] core_src_full  = '0;
    logic [W-1:0]  core_src_data;
    logic [NC-1:0] core_res_empty = '1;
    logic [NC*W-1:0] core_res_data = '0;
    logic [NC-1:0] core_res_rden;
    logic          sink_fifo_wren;
    logic          sink_fifo_full = 1'b0;
    logic [W-1:0]  sink_fifo_data;
    logic          sink_fifo_last;
    logic [31:0]   n_dispatched;
    logic [31:0]   n_returned;

    dtw_sched #(
        .NUM_CORES  (NC),
        .AXIS_WIDTH (W),
        .SQG_SIZE   (SQ)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs             (rs),
        .busy           (busy),
        .src_fifo_empty (src_fifo_empty),
        .src_fifo_data  (src_fifo_data),
        .src_fifo_rden  (src_fifo_rden),
        .core_src_wren  (core_src_wren),
        .core_src_full  (core_src_full),
        .core_src_data  (core_src_data),
        .core_res_empty (core_res_empty),
        .core_res_data  (core_res_data),
        .core_res_rden  (core_res_rden),
        .sink_fifo_wren (sink_fifo_wren),
        .sink_fifo_full (sink_fifo_full),
        .sink_fifo_data (sink_fifo_data),
        .sink_fifo_last (sink_fifo_last),
        .n_dispatched   (n_dispatched),
        .n_returned     (n_returned)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  src_q[$];
    logic [W-1:0]  res_q[NC][$];
    logic [NC-1:0] cfull  = '0;
    logic          sf_tog = 1'b0;

    logic [W-1:0] wr_word[$];
    int           wr_core[$];
    int           wr_cyc[$];
    int           rp_cyc[$];
    logic [W-1:0] sk_word[$];
    logic         sk_last[$];

    logic [W-1:0] exp_src[$];
    int           exp_core[$];
    logic [W-1:0] exp_sink[$];

    int cyc      = 0;
    int rden_cnt = 0;
    int n_assert = 0;
    int n_fail   = 0;

    // Sample handshakes at the edge (pre-update values), pop FIFO models.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (src_fifo_rden) begin
                rden_cnt++;
                if (src_q.size() > 0) void'(src_q.pop_front());
            end
            for (int i = 0; i < NC; i++) begin
                if (core_src_wren[i]) begin
                    wr_word.push_back(core_src_data);
                    wr_core.push_back(i);
                    wr_cyc.push_back(cyc);
                end
                if (core_res_rden[i] && res_q[i].size() > 0) begin
                    void'(res_q[i].pop_front());
                    rp_cyc.push_back(cyc);
                end
            end
            if (sink_fifo_wren) begin
                sk_word.push_back(sink_fifo_data);
                sk_last.push_back(sink_fifo_last);
            end
        end
    end

    // Present FWFT FIFO heads and flow control on the far edge.
    always @(negedge clk) begin
        src_fifo_empty = (src_q.size() == 0);
        src_fifo_data  = '0;
        if (src_q.size() > 0) src_fifo_data = src_q[0];
        for (int i = 0; i < NC; i++) begin
            core_res_empty[i]       = (res_q[i].size() == 0);
            core_res_data[i*W +: W] = '0;
            if (res_q[i].size() > 0) core_res_data[i*W +: W] = res_q[i][0];
        end
        core_src_full  = cfull;
        sink_fifo_full = sf_tog ? !sink_fifo_full : 1'b0;
    end

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pkt(input logic [W-1:0] qid, input int core);
        logic [W-1:0] w;
        src_q.push_back(qid);
        exp_src.push_back(qid);
        for (int i = 0; i < SQ; i++) begin
            w = $urandom;
            src_q.push_back(w);
            exp_src.push_back(w);
        end
        exp_core.push_back(core);
    endtask

    task automatic push_res(input int core, input logic [W-1:0] qid);
        logic [W-1:0] w;
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? qid : $urandom;
            res_q[core].push_back(w);
            exp_sink.push_back(w);
        end
    endtask

    task automatic wait_disp(input int n);
        int k = 0;
        while (n_dispatched != n && k < 400) begin
            tick(1);
            k++;
        end
        chk($sformatf("wait_disp%0d", n), n_dispatched, n);
    endtask

    task automatic wait_ret(input int n);
        int k = 0;
        while (n_returned != n && k < 400) begin
            tick(1);
            k++;
        end
        chk($sformatf("wait_ret%0d", n), n_returned, n);
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (wr_word.size() < n && k < 400) begin
            tick(1);
            k++;
        end
        chk($sformatf("wait_wr%0d", n), wr_word.size(), n);
    endtask

    // Packet p must appear as 9 consecutive writes, all to its expected core.
    task automatic check_pkts(input int first, input int last);
        for (int p = first; p <= last; p++) begin
            int ok;
            int core;
            ok   = 1;
            core = -1;
            if (wr_word.size() < (p + 1) * PK) begin
                ok = 0;
            end else begin
                core = wr_core[p*PK];
                for (int j = 0; j < PK; j++) begin
                    if (wr_word[p*PK+j] !== exp_src[p*PK+j]) ok = 0;
                    if (wr_core[p*PK+j] != core) ok = 0;
                end
            end
            chk($sformatf("pkt%0d_words", p), ok, 1);
            chk($sformatf("pkt%0d_core", p), core, exp_core[p]);
        end
    endtask

    task automatic check_sink(input string tag);
        int ok;
        ok = (sk_word.size() == exp_sink.size()) ? 1 : 0;
        if (ok == 1) begin
            for (int i = 0; i < sk_word.size(); i++) begin
                if (sk_word[i] !== exp_sink[i]) ok = 0;
                if (sk_last[i] !== ((i % 3) == 2)) ok = 0;
            end
        end
        chk({tag, "_count"}, sk_word.size(), exp_sink.size());
        chk({tag, "_order_last"}, ok, 1);
    endtask

    initial begin
        int r0;
        int cnt;
        int base;

        tick(3);
        chk("rst_rden",  src_fifo_rden, 0);
        chk("rst_wren",  core_src_wren, 0);
        chk("rst_rrden", core_res_rden, 0);
        chk("rst_swren", sink_fifo_wren, 0);
        chk("rst_slast", sink_fifo_last, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cdata", core_src_data, 0);
        chk("rst_sdata", sink_fifo_data, 0);
        chk("rst_ndisp", n_dispatched, 0);
        chk("rst_nret",  n_returned, 0);
        rst = 1'b0;
        tick(2);

        rs = 1'b1;
        for (int q = 0; q < 4; q++) push_pkt(W'(10 + q), q);
        wait_disp(4);
        tick(2);
        check_pkts(0, 3);
        for (int c = 0; c < NC; c++) begin
            cnt = 0;
            foreach (wr_core[i]) if (wr_core[i] == c) cnt++;
            chk($sformatf("core%0d_words", c), cnt, PK);
        end
        chk("disp_gap", wr_cyc[PK] - wr_cyc[PK-1], 3);
        chk("busy_alloc", busy, 1);

        r0 = rden_cnt;
        push_pkt(32'd14, 2);
        tick(20);
        chk("full_hold_rden", rden_cnt - r0, 0);
        chk("full_hold_disp", n_dispatched, 4);
        push_res(2, 32'd12);
        wait_disp(5);
        wait_ret(1);
        tick(3);
        check_pkts(4, 4);
        chk("resume_lat", wr_cyc[4*PK] - rp_cyc[2], 2);
        check_sink("sink_b");

        push_res(0, 32'd10);
        wait_ret(2);
        tick(3);
        push_res(1, 32'd11);
        push_res(3, 32'd13);
        wait_ret(4);
        tick(3);
        check_sink("sink_merge");

        sf_tog = 1'b1;
        push_pkt(32'd15, 3);
        push_pkt(32'd16, 0);
        push_res(2, 32'd14);
        wait_wr(6 * PK + 4);
        cfull[0] = 1'b1;
        tick(5);
        cfull[0] = 1'b0;
        wait_disp(7);
        wait_ret(5);
        sf_tog = 1'b0;
        tick(4);
        check_pkts(5, 6);
        check_sink("sink_bp");

        push_pkt(32'd17, 1);
        push_pkt(32'd18, 2);
        wait_wr(7 * PK + 4);
        rs = 1'b0;
        wait_disp(8);
        r0 = rden_cnt;
        tick(20);
        chk("rs_hold_rden", rden_cnt - r0, 0);
        chk("rs_hold_disp", n_dispatched, 8);
        chk("rs_src_left", src_q.size(), PK);
        rs = 1'b1;
        wait_disp(9);
        tick(2);
        check_pkts(7, 8);

        push_res(0, 32'd16);
        wait_ret(6);
        tick(3);
        check_sink("sink_final");
        chk("wr_total", wr_word.size(), exp_src.size());

        push_pkt(32'd19, 0);
        wait_wr(9 * PK + 3);
        rst = 1'b1;
        #1;
        chk("mrst_rden",  src_fifo_rden, 0);
        chk("mrst_wren",  core_src_wren, 0);
        chk("mrst_cdata", core_src_data, 0);
        chk("mrst_rrden", core_res_rden, 0);
        chk("mrst_swren", sink_fifo_wren, 0);
        chk("mrst_slast", sink_fifo_last, 0);
        chk("mrst_sdata", sink_fifo_data, 0);
        chk("mrst_busy",  busy, 0);
        chk("mrst_alloc", dut.alloc_q, 0);
        chk("mrst_ndisp", n_dispatched, 0);
        chk("mrst_nret",  n_returned, 0);
        src_q.delete();
        for (int i = 0; i < NC; i++) res_q[i].delete();
        tick(2);
        rst = 1'b0;
        r0 = rden_cnt;
        tick(5);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rden", rden_cnt - r0, 0);
        chk("post_rst_ndisp", n_dispatched, 0);

        base = wr_word.size();
        push_pkt(32'd20, 0);
        wait_disp(1);
        tick(2);
        chk("recov_count", wr_word.size() - base, PK);
        if (wr_word.size() > base) begin
            chk("recov_core", wr_core[base], 0);
            chk("recov_qid", wr_word[base], 20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
